// File: rtl/normalizer64_seq.sv
// normalizer64_seq: iterative left-normalizer for 64-bit operands.
// Derives the left-shift count through a binary search on step sizes
// 32, 16, 8, 4, 2, 1. STEPS_PER_CYCLE of those steps run each clock.
// The parameter must divide 6 (legal values 1, 2, 3, 6).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an operand, in_ready high
// SEARCH | binary search in progress, handshakes closed
// DONE   | result presented, held until out_ready; may accept the next operand
`timescale 1ns/1ps

module normalizer64_seq #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in,
    input  logic        norm_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [5:0]  shift_amount,
    output logic        zero
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] work_q, work_d;
    logic [5:0]  count_q, count_d;
    logic        zero_q, zero_d;
    logic        type_q, type_d;
    logic [2:0]  step_q, step_d;

    logic [63:0] srch_work;
    logic [5:0]  srch_count;
    logic        srch_last;
    logic        accept;

    // Handshake signals come straight from state (plus out_ready in DONE).
    assign in_ready     = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid    = (state_q == DONE);
    assign accept       = in_valid && in_ready;
    assign result       = work_q;
    assign shift_amount = count_q;
    assign zero         = zero_q;

    // One clock's worth of search steps, starting at step index step_q.
    // The working value doubles as the result register, so the last step
    // leaves the normalized operand in place for DONE.
    always_comb begin
        int          idx;
        int          s;
        logic        hit;
        logic [63:0] top;
        srch_work  = work_q;
        srch_count = count_q;
        idx        = 0;
        s          = 0;
        hit        = 1'b0;
        top        = 64'd0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            idx = int'(step_q) + i;
            hit = 1'b0;
            if (idx <= 5) begin
                s = 32 >> idx;
                if (type_q) begin
                    // Signed: top s+1 bits identical means s redundant sign bits.
                    top = srch_work >> (63 - s);
                    hit = (top == 64'd0) || (top == ((64'd1 << (s + 1)) - 64'd1));
                end else begin
                    top = srch_work >> (64 - s);
                    hit = (top == 64'd0);
                end
                if (hit) begin
                    srch_work  = srch_work << s;
                    srch_count = srch_count + 6'(s);
                end
            end
        end
        srch_last = (int'(step_q) + STEPS_PER_CYCLE >= 6);
    end

    // Next-state and next-register logic for the sequencer.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        zero_d  = zero_q;
        type_d  = type_q;
        step_d  = step_q;
        case (state_q)
            IDLE: ;
            SEARCH: begin
                work_d  = srch_work;
                count_d = srch_count;
                step_d  = step_q + 3'(STEPS_PER_CYCLE);
                if (srch_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Acceptance is possible from IDLE and from DONE on a result handshake.
        if (accept) begin
            state_d = SEARCH;
            work_d  = in;
            count_d = 6'd0;
            zero_d  = (in == 64'd0);
            type_d  = norm_type;
            step_d  = 3'd0;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 64'd0;
            count_q <= 6'd0;
            zero_q  <= 1'b0;
            type_q  <= 1'b0;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            type_q  <= type_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: tb/tb_normalizer64_seq.sv
// Bench for normalizer64_seq: four instances (1, 2, 3, 6 steps per cycle)
// share stimulus and are checked against a bit-counting reference model.
`timescale 1ns/1ps

module tb_normalizer64_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] din = 64'd0;
    logic        ntype = 1'b0;
    logic        out_ready = 1'b0;

    logic        ir  [4];
    logic        ov  [4];
    logic [63:0] res [4];
    logic [5:0]  amt [4];
    logic        zr  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        normalizer64_seq #(
            .STEPS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6)
        ) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid     (in_valid),
            .in_ready     (ir[g]),
            .in           (din),
            .norm_type    (ntype),
            .out_valid    (ov[g]),
            .out_ready    (out_ready),
            .result       (res[g]),
            .shift_amount (amt[g]),
            .zero         (zr[g])
        );
    end

    function automatic int steps_of(int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
    endfunction

    // Reference: count leading zeros, or bits below the MSB equal to the MSB.
    function automatic int ref_amount(logic [63:0] v, logic t);
        int  n = 0;
        bit  run = 1'b1;
        if (!t) begin
            for (int i = 63; i >= 0; i--) begin
                if (run && v[i] == 1'b0) n++;
                else run = 1'b0;
            end
        end else begin
            for (int i = 62; i >= 0; i--) begin
                if (run && v[i] == v[63]) n++;
                else run = 1'b0;
            end
        end
        if (n > 63) n = 63;
        return n;
    endfunction

    task automatic check(input string tag, input int inst,
                         input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s inst%0d observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    // Present an operand at the next negedge; all instances accept at the posedge.
    task automatic launch(input logic [63:0] v, input logic t);
        @(negedge clk);
        in_valid = 1'b1;
        din      = v;
        ntype    = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = ~v ^ {$urandom, $urandom};
        ntype    = ~t;
    endtask

    // Wait for every instance's result (bounded) and check value and latency.
    task automatic collect(input logic [63:0] er, input logic [5:0] ea, input logic ez);
        int lat [4];
        bit seen [4];
        for (int g = 0; g < 4; g++) begin
            lat[g]  = 0;
            seen[g] = 1'b0;
        end
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                if (!seen[g] && ov[g]) begin
                    seen[g] = 1'b1;
                    lat[g]  = cyc;
                    check("result", g, res[g], er);
                    check("shift_amount", g, 64'(amt[g]), 64'(ea));
                    check("zero", g, 64'(zr[g]), 64'(ez));
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            check("latency", g, 64'(lat[g]), 64'(6 / steps_of(g)));
        end
    endtask

    // Complete the result handshake with no new operand; all return to IDLE.
    task automatic release_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            check("idle_out_valid", g, 64'(ov[g]), 64'd0);
            check("idle_in_ready", g, 64'(ir[g]), 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] v;
        logic        t;
        int          a;

        // Reset state, including in_ready while reset is held.
        #1 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            check("rst_out_valid", g, 64'(ov[g]), 64'd0);
            check("rst_in_ready", g, 64'(ir[g]), 64'd1);
            check("rst_result", g, res[g], 64'd0);
            check("rst_amount", g, 64'(amt[g]), 64'd0);
            check("rst_zero", g, 64'(zr[g]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // in_valid low in IDLE: nothing happens.
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) check("idle_hold", g, 64'(ov[g]), 64'd0);

        // Directed cases with hand-derived expectations.
        launch(64'h0000_0000_0000_0001, 1'b0);
        collect(64'h8000_0000_0000_0000, 6'd63, 1'b0);
        release_out();
        launch(64'h0, 1'b0);
        collect(64'h0, 6'd63, 1'b1);
        release_out();
        launch(64'h8000_0000_0000_0000, 1'b0);
        collect(64'h8000_0000_0000_0000, 6'd0, 1'b0);
        release_out();
        launch(64'hFFFF_FFFF_FFFF_FF00, 1'b1);
        collect(64'h8000_0000_0000_0000, 6'd55, 1'b0);
        release_out();
        launch(64'h0000_0000_0000_00FF, 1'b1);
        collect(64'h7F80_0000_0000_0000, 6'd55, 1'b0);
        release_out();
        launch(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        collect(64'h8000_0000_0000_0000, 6'd63, 1'b0);
        release_out();
        launch(64'h0, 1'b1);
        collect(64'h0, 6'd63, 1'b1);
        release_out();
        launch(64'h4000_0000_0000_0001, 1'b1);
        collect(64'h4000_0000_0000_0001, 6'd0, 1'b0);
        release_out();

        // Backpressure: results hold for three cycles, then a back-to-back accept.
        launch(64'h0000_0000_00F0_0000, 1'b0);
        collect(64'hF000_0000_0000_0000, 6'd40, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                check("bp_out_valid", g, 64'(ov[g]), 64'd1);
                check("bp_in_ready", g, 64'(ir[g]), 64'd0);
                check("bp_result", g, res[g], 64'hF000_0000_0000_0000);
                check("bp_amount", g, 64'(amt[g]), 64'd40);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din       = 64'hFFFF_FFFF_FFFF_8000;
        ntype     = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) check("b2b_in_ready", g, 64'(ir[g]), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = 64'h1234_5678_9ABC_DEF0;
        ntype     = 1'b0;
        for (int g = 0; g < 4; g++) check("b2b_accepted", g, 64'(ov[g]), 64'd0);
        collect(64'h8000_0000_0000_0000, 6'd48, 1'b0);
        release_out();

        // Asynchronous reset two cycles into SEARCH, then a fresh operand.
        launch(64'h0000_0000_0000_0F00, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            check("abort_out_valid", g, 64'(ov[g]), 64'd0);
            check("abort_result", g, res[g], 64'd0);
            check("abort_amount", g, 64'(amt[g]), 64'd0);
            check("abort_in_ready", g, 64'(ir[g]), 64'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        launch(64'h0000_0001_0000_0000, 1'b0);
        collect(64'h8000_0000_0000_0000, 6'd31, 1'b0);
        release_out();

        // Random operands in both modes against the reference model.
        for (int n = 0; n < 2000; n++) begin
            v = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) v = ~v;
            if ($urandom_range(0, 31) == 0) v = 64'd0;
            t = 1'($urandom_range(0, 1));
            a = ref_amount(v, t);
            launch(v, t);
            collect(v << a, 6'(a), v == 64'd0);
            release_out();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
